// File: rtl/iiitb_icg_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// iiitb_icg_if : clock-enable request, demo flop data and gated-clock outputs
// Rev 1.0
// ============================================================================
interface iiitb_icg_if #(
  parameter int WIDTH = 1
);
  logic             in;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic             cgclk;
  logic             q_l;

  modport master (
    output in, d0, d1,
    input  q0, q1, cgclk, q_l
  );

  modport slave (
    input  in, d0, d1,
    output q0, q1, cgclk, q_l
  );
endinterface
`default_nettype wire

// File: rtl/iiitb_icg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// iiitb_icg : latch-based clock gate driving a reference flop and a gated flop
// Rev 1.0
// ============================================================================
module iiitb_icg #(
  parameter int WIDTH = 1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  iiitb_icg_if.slave  bus
);

  logic             r_q_l;
  logic             w_cgclk;
  logic [WIDTH-1:0] r_q0;
  logic [WIDTH-1:0] r_q1;

  // Enable is only allowed to move while clk is low, so cgclk never glitches.
  always_latch begin
    if (!rst_n) begin
      r_q_l <= 1'b0;
    end else if (!clk) begin
      r_q_l <= bus.in;
    end
  end

  assign w_cgclk = clk & r_q_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q0 <= '0;
    end else begin
      r_q0 <= bus.d0;
    end
  end

  always_ff @(posedge w_cgclk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '0;
    end else begin
      r_q1 <= bus.d1;
    end
  end

  assign bus.q_l   = r_q_l;
  assign bus.cgclk = w_cgclk;
  assign bus.q0    = r_q0;
  assign bus.q1    = r_q1;

endmodule
`default_nettype wire

// File: tb/tb_iiitb_icg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_iiitb_icg : directed checks plus a cycle-by-cycle reference model
// Rev 1.0
// ============================================================================
module tb_iiitb_icg;

  logic clk;
  logic rst_n;

  iiitb_icg_if #(.WIDTH(1)) bus ();

  iiitb_icg #(.WIDTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: enable seen at the last rising edge and the two flop images.
  logic en_m;
  logic q0_m;
  logic q1_m;

  int      cg_rises = 0;
  realtime t_rise   = 0.0;
  realtime last_w   = 0.0;

  initial begin
    clk = 1'b0;
    forever #3 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_m = 1'b0;
      q0_m = 1'b0;
      q1_m = 1'b0;
    end else begin
      en_m = bus.in;
      q0_m = bus.d0;
      if (en_m) q1_m = bus.d1;
    end
  end

  always @(posedge bus.cgclk) begin
    cg_rises++;
    t_rise = $realtime;
  end

  // Every complete gated pulse must span a full clk high phase (3 ns).
  always @(negedge bus.cgclk) begin
    last_w = $realtime - t_rise;
    if (rst_n === 1'b1) chk("pulse_width_x10", int'(last_w * 10.0), 30);
  end

  initial begin
    logic q_l_exp;
    #0.6;
    forever begin
      q_l_exp = !rst_n ? 1'b0 : (clk ? en_m : bus.in);
      chk("model_q_l",   bus.q_l,   q_l_exp);
      chk("model_cgclk", bus.cgclk, clk & q_l_exp);
      chk("model_q0",    bus.q0,    q0_m);
      chk("model_q1",    bus.q1,    q1_m);
      #1;
    end
  end

  initial begin
    int c0;
    rst_n  = 1'b1;
    bus.in = 1'b1;
    bus.d0 = 1'b1;
    bus.d1 = 1'b1;
    #0.1 rst_n = 1'b0;
    #0.1;
    #20;
    chk("rst_q0",    bus.q0,    0);
    chk("rst_q1",    bus.q1,    0);
    chk("rst_q_l",   bus.q_l,   0);
    chk("rst_cgclk", bus.cgclk, 0);

    // Released while clk is low: the latch opens at once.
    rst_n = 1'b1;
    #0.1 chk("rel_q_l", bus.q_l, 1);
    @(posedge clk) #0.5;
    chk("rel_q0",    bus.q0,    1);
    chk("rel_q1",    bus.q1,    1);
    chk("rel_cgclk", bus.cgclk, 1);
    #0.7;

    // Enable held high: every clk pulse passes, q1 tracks like q0.
    c0 = cg_rises;
    repeat (5) begin
      #6;
      bus.d0 = ~bus.d0;
      bus.d1 = ~bus.d1;
    end
    chk("hi_cg_rises", cg_rises - c0, 5);
    #6;
    chk("hi_q0", bus.q0, 0);
    chk("hi_q1", bus.q1, 0);

    // Enable held low: q1 frozen, no gated pulses.
    bus.d1 = 1'b1;
    bus.d0 = 1'b0;
    #12;
    bus.in = 1'b0;
    #6;
    c0 = cg_rises;
    repeat (6) begin
      #7;
      bus.d1 = ~bus.d1;
      bus.d0 = ~bus.d0;
    end
    chk("lo_cg_rises", cg_rises - c0, 0);
    chk("lo_q1",       bus.q1,        1);

    // Enable pulse wholly inside a clk high phase is ignored.
    @(posedge clk) #0.5;
    bus.in = 1'b1;
    #1 bus.in = 1'b0;
    #1 chk("glitch_q_l", bus.q_l, 0);
    c0 = cg_rises;
    @(posedge clk) #0.5;
    chk("glitch_cg_rises", cg_rises - c0, 0);
    chk("glitch_q1",       bus.q1,        1);

    // Enable rising during clk low passes the next full high phase.
    @(negedge clk) #0.5;
    bus.in = 1'b1;
    #0.1;
    chk("lowrise_q_l",   bus.q_l,   1);
    chk("lowrise_cgclk", bus.cgclk, 0);
    @(posedge clk) #0.5;
    chk("lowrise_cg_high", bus.cgclk, 1);
    @(negedge clk) #0.5;
    chk("lowrise_width_x10", int'(last_w * 10.0), 30);
    #0.7;

    // Free-running mix of enable and data activity.
    fork
      repeat (25) begin #8 bus.in = ~bus.in; end
      repeat (40) begin #5 bus.d0 = ~bus.d0; end
      repeat (28) begin #7 bus.d1 = ~bus.d1; end
    join

    // Asynchronous reset in the middle of a gated pulse.
    bus.in = 1'b1;
    bus.d0 = 1'b1;
    bus.d1 = 1'b1;
    #12;
    @(posedge clk) #0.5;
    chk("pre_q_l",   bus.q_l,   1);
    chk("pre_cgclk", bus.cgclk, 1);
    chk("pre_q0",    bus.q0,    1);
    chk("pre_q1",    bus.q1,    1);
    rst_n = 1'b0;
    #0.01;
    chk("async_q_l",   bus.q_l,   0);
    chk("async_cgclk", bus.cgclk, 0);
    chk("async_q0",    bus.q0,    0);
    chk("async_q1",    bus.q1,    0);
    #4.69;
    #6;
    rst_n = 1'b1;
    #12;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iiitb_icg.md
Name: iiitb_icg

Overview:
- Latch-based integrated clock gate (ICG) with two demonstration flops.
- A negative-level enable latch qualifies the free-running clock into a glitch-free gated clock `cgclk`.
- `q0` is a reference flop on the ungated clock; `q1` is the same flop on the gated clock.
- Used as a low-power clock-gating cell and demonstrator at the leaf of a clock tree.

Parameters:
- WIDTH, 1, bit width of `d0`/`d1`/`q0`/`q1`; the default build is scalar.

Ports:
- clk    input   1      free-running clock
- rst_n  input   1      asynchronous active-low reset
- in     input   1      clock enable request
- d0     input   WIDTH  data to ungated flop
- d1     input   WIDTH  data to gated flop
- q0     output  WIDTH  register of d0, clocked by clk
- q1     output  WIDTH  register of d1, clocked by cgclk
- cgclk  output  1      gated clock = clk AND q_l
- q_l    output  1      enable latch output

Behaviour:
- Enable latch:
  - Transparent while clk==0: q_l follows `in`.
  - Opaque while clk==1: q_l holds the value present at the clk rising edge.
  - Implemented as a level-sensitive latch, not a flop.
- Gated clock:
  - cgclk = clk & q_l, purely combinational.
  - Because q_l changes only while clk==0, cgclk has no glitches and no truncated high pulses.
  - Each cgclk pulse is either a full clk high phase or absent.
- Enable timing:
  - A change on `in` during clk low takes effect on the next clk rising edge.
  - A change during clk high is ignored until clk falls, i.e. it applies one edge later.
- q0:
  - Captures d0 on every posedge clk; 1-cycle latency.
- q1:
  - Captures d1 on posedge cgclk only, i.e. posedge clk when q_l==1; otherwise holds.
- Reset (rst_n==0, asynchronous, immediate, independent of clk):
  - q_l=0, hence cgclk=0.
  - q0=0 and q1=0.
  - Outputs stay in that state while rst_n is low.
- Reset release:
  - Takes effect asynchronously.
  - The latch resumes transparency at the next clk low phase.
  - Flops resume at the next qualifying rising edge.
- Reset mid-operation:
  - Any in-flight cgclk high pulse is truncated to 0 immediately.
  - Accepted as reset-only behaviour.
- Simultaneous events:
  - `in` toggling exactly at the clk rising edge uses the pre-edge value; the latch closes on the edge.
  - d0/d1 toggling at the capture edge: the pre-edge value is captured.
- cgclk is a gated clock only and must never be used as data.
- No X propagation on outputs after reset.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 with clk toggling, in=1, d0=d1=1.
  - Required: q0=q1=0, q_l=0, cgclk=0 throughout; after rst_n rises, q0=1 at the first posedge clk.
- Enable held high:
  - Stimulus: in=1 steady, clk period 6.
  - Required: cgclk identical to clk from the first rising edge after the latch opens; q1 tracks d1 with the same 1-cycle latency as q0 tracks d0.
- Enable held low:
  - Stimulus: in=0 steady, d1 toggling every 7.
  - Required: cgclk=0 constantly and q1 frozen at its last value; q0 still follows d0.
- Glitch immunity:
  - Stimulus: pulse in 0→1→0 entirely within a clk-high phase.
  - Required: q_l unchanged and no cgclk pulse.
  - Stimulus: in rises during clk low.
  - Required: q_l rises immediately and the next clk high phase appears in full on cgclk.
- Free-running mix:
  - Stimulus: in toggles every 8, d0 every 5, d1 every 7, clk every 3, 200 time units.
  - Required: cgclk == clk & q_l at all times; no cgclk high pulse shorter than a clk high phase; q1 changes only on cgclk rising edges.
- Async reset mid-pulse:
  - Stimulus: assert rst_n=0 while clk=1 and q_l=1.
  - Required: cgclk and q_l drop to 0 immediately (same timestep); q0/q1 clear without a clock edge.
